// File: rtl/adder_arbiter.sv
// Two-requester front end sharing one adder_nbit, with a one-deep result register.
// Optional per-requester grant counters are enabled by defining ADDER_ARB_STATS_EN.
//
// state | meaning
// EMPTY | result register holds nothing (rsp_valid = 0)
// FULL  | result register holds a result awaiting rsp_ready (rsp_valid = 1)

module adder_nbit #(
    parameter int BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
endmodule

module adder_arbiter #(
    parameter int BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [BIT_WIDTH-1:0] req_a0,
    input  logic [BIT_WIDTH-1:0] req_b0,
    input  logic [BIT_WIDTH-1:0] req_a1,
    input  logic [BIT_WIDTH-1:0] req_b1,
    input  logic [1:0]           req_cin,
    output logic [1:0]           req_ready,
    output logic                 rsp_valid,
    output logic [BIT_WIDTH-1:0] rsp_sum,
    output logic                 rsp_overflow,
    output logic                 rsp_id,
    input  logic                 rsp_ready,
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t               state, state_next;
    logic                 last_grant;
    logic                 grant0, grant1;
    logic                 space_ok;
    logic                 accept;
    logic [BIT_WIDTH-1:0] op_a, op_b;
    logic                 op_cin;
    logic [BIT_WIDTH-1:0] add_sum;
    logic                 add_cout;

    assign rsp_valid = (state == FULL);
    assign space_ok  = ~rsp_valid | rsp_ready;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = req_valid[0] & (~req_valid[1] | last_grant);
    assign grant1 = req_valid[1] & (~req_valid[0] | ~last_grant);

    assign req_ready = rst ? 2'b00 : {grant1 & space_ok, grant0 & space_ok};
    assign accept    = |req_ready;

    assign op_a   = grant1 ? req_a1 : req_a0;
    assign op_b   = grant1 ? req_b1 : req_b0;
    assign op_cin = grant1 ? req_cin[1] : req_cin[0];

    adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
        .a         (op_a),
        .b         (op_b),
        .carry_in  (op_cin),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum      <= '0;
            rsp_overflow <= 1'b0;
            rsp_id       <= 1'b0;
            last_grant   <= 1'b1;
        end else if (accept) begin
            rsp_sum      <= add_sum;
            rsp_overflow <= add_cout;
            rsp_id       <= req_ready[1];
            last_grant   <= req_ready[1];
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req_ready[0] && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req_ready[1] && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
`endif

endmodule
